// File: rtl/attosoc_pkg.sv
// attosoc_pkg: shared definitions for attosoc peripherals.
//   - UART register offsets (word index, iomem_addr[3:2])
//   - UART STATUS bit positions
//   - UART serialiser and bus-handshake state encodings
//   - Minimum effective baud divider and a clamp helper
package attosoc_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  localparam int UART_STAT_FULL      = 0;
  localparam int UART_STAT_EMPTY     = 1;
  localparam int UART_STAT_BUSY      = 2;
  localparam int UART_STAT_COUNT_LSB = 4;

  localparam logic [15:0] UART_DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } uart_bus_state_e;

  // Effective divider used by the serialiser; the stored register keeps
  // whatever software wrote.
  function automatic logic [15:0] uart_clamp_div(input logic [15:0] div);
    return (div < UART_DIV_MIN) ? UART_DIV_MIN : div;
  endfunction

endpackage

// File: rtl/attosoc_sync_fifo.sv
// attosoc_sync_fifo: single-clock show-ahead FIFO.
//   clk, resetn  clock and synchronous active-low reset (empties the FIFO)
//   push_i       write wdata_i when not full
//   wdata_i      write data
//   pop_i        drop head entry when not empty
//   rdata_o      head entry (valid while !empty_o)
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module attosoc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH + 1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  // Full/empty come from the count at the start of the cycle, so a push
  // into a full FIFO is refused even if a pop happens on the same edge.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/attosoc_uart_tx.sv
// attosoc_uart_tx: memory-mapped 8N1 UART transmitter on the picorv32
// iomem bus.
//   clk, resetn   clock, synchronous active-low reset
//   iomem_valid   bus request
//   iomem_ready   one-cycle completion strobe
//   iomem_addr    byte address; [31:4] selects the window, [3:2] the register
//   iomem_wdata   write data
//   iomem_wstrb   byte strobes, 0 = read
//   iomem_rdata   read data, registered, valid while iomem_ready = 1
//   ser_tx        serial output, idle high
// Registers: 0 DATA (push byte), 1 STATUS (RO), 2 DIV (bit period = DIV+1).
module attosoc_uart_tx
  import attosoc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_rdata,
  output logic        ser_tx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- bus side
  uart_bus_state_e bus_state_q, bus_state_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     read_mux;
  logic [15:0]     div_q, div_d;
  logic            sel;
  logic            is_write;
  logic            is_data_push;
  logic [1:0]      reg_off;

  // ---------------------------------------------------------------- FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // ---------------------------------------------------------------- serialiser
  uart_tx_state_e tx_state_q, tx_state_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    bit_div_q, bit_div_d;
  logic [15:0]    baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           ser_tx_q;
  logic           stop_tail_q;
  logic           tx_bit;
  logic           tx_busy;
  logic           load;

  // Bits of the bus that carry no information for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{iomem_addr[1:0], iomem_wdata[31:16]};

  assign sel          = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off      = iomem_addr[3:2];
  assign is_write     = |iomem_wstrb;
  assign is_data_push = iomem_wstrb[0] && (reg_off == UART_REG_DATA);

  // ser_tx lags the serialiser state by one register stage, so the tail
  // flag keeps busy asserted through the final stop-bit cycle on the pin.
  assign tx_busy = (tx_state_q != TX_IDLE) || stop_tail_q;

  always_comb begin
    read_mux = '0;
    case (reg_off)
      UART_REG_STATUS: begin
        read_mux[UART_STAT_FULL]                 = fifo_full;
        read_mux[UART_STAT_EMPTY]                = fifo_empty;
        read_mux[UART_STAT_BUSY]                 = tx_busy;
        read_mux[UART_STAT_COUNT_LSB +: 4]       = 4'(fifo_count);
      end
      UART_REG_DIV: read_mux[15:0] = div_q;
      default:      read_mux = '0;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bus_state_d = BUS_IDLE;  // ACK always lasts exactly one cycle
    rdata_d     = '0;
    div_d       = div_q;
    fifo_push   = 1'b0;
    // A DATA write into a full FIFO waits in IDLE until a slot frees up.
    if (bus_state_q == BUS_IDLE && sel && !(is_data_push && fifo_full)) begin
      bus_state_d = BUS_ACK;
      if (!is_write) begin
        rdata_d = read_mux;
      end else begin
        fifo_push = is_data_push;
        if (reg_off == UART_REG_DIV) begin
          if (iomem_wstrb[0]) div_d[7:0]  = iomem_wdata[7:0];
          if (iomem_wstrb[1]) div_d[15:8] = iomem_wdata[15:8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_state_q <= BUS_IDLE;
      rdata_q     <= '0;
      div_q       <= DEFAULT_DIV;
    end else begin
      bus_state_q <= bus_state_d;
      rdata_q     <= rdata_d;
      div_q       <= div_d;
    end
  end

  assign iomem_ready = (bus_state_q == BUS_ACK);
  assign iomem_rdata = rdata_q;

  attosoc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .wdata_i (iomem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Each state holds for bit_div_q+1 cycles: baud_cnt counts down to 0.
  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    bit_div_d  = bit_div_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    tx_bit     = 1'b1;
    case (tx_state_q)
      TX_IDLE: load = !fifo_empty;
      TX_START: begin
        tx_bit = 1'b0;
        if (baud_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          baud_cnt_d = bit_div_q;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        tx_bit = shift_q[0];
        if (baud_cnt_q == '0) begin
          baud_cnt_d = bit_div_q;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        tx_bit = 1'b1;
        if (baud_cnt_q == '0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) load = 1'b1;
          else             tx_state_d = TX_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Divider is captured here so a DIV write mid-byte only affects the
    // following byte.
    if (load) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rdata;
      bit_div_d  = uart_clamp_div(div_q);
      baud_cnt_d = uart_clamp_div(div_q);
      tx_state_d = TX_START;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q  <= TX_IDLE;
      shift_q     <= '0;
      bit_div_q   <= UART_DIV_MIN;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      ser_tx_q    <= 1'b1;
      stop_tail_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      shift_q     <= shift_d;
      bit_div_q   <= bit_div_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      ser_tx_q    <= tx_bit;
      stop_tail_q <= (tx_state_q == TX_STOP);
    end
  end

  assign ser_tx = ser_tx_q;

endmodule

// File: tb/tb_attosoc_uart_tx.sv
// Directed bench for attosoc_uart_tx: bus accesses through a small task,
// a line monitor that decodes 8N1 frames with a 4-clock bit period, and
// hand-computed expectations.
module tb_attosoc_uart_tx;

  localparam logic [31:0] A_DATA   = 32'h0200_0000;
  localparam logic [31:0] A_STATUS = 32'h0200_0004;
  localparam logic [31:0] A_DIV    = 32'h0200_0008;
  localparam logic [31:0] A_R3     = 32'h0200_000C;
  localparam int          BIT_CLKS = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_rdata;
  logic        ser_tx;

  attosoc_uart_tx dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .iomem_rdata (iomem_rdata),
    .ser_tx      (ser_tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ line monitor
  logic       in_frame = 1'b0;
  int         fidx = 0;
  int         fstart = 0;
  logic [39:0] frame_bits = '0;
  logic [7:0] mon_b;
  bit         mon_ok;
  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  bit         rx_ok[$];
  int         fall_cnt = 0;
  int         ready_cycles = 0;

  always @(negedge clk) begin
    if (iomem_ready === 1'b1) ready_cycles++;
    if (!resetn) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (ser_tx === 1'b0) begin
        in_frame = 1'b1;
        frame_bits = '0;
        fidx = 1;
        fstart = cyc;
        fall_cnt++;
      end
    end else begin
      frame_bits[fidx] = ser_tx;
      fidx++;
      if (fidx == 10 * BIT_CLKS) begin
        mon_ok = 1'b1;
        for (int k = 0; k < 10; k++)
          for (int s = 1; s < BIT_CLKS; s++)
            if (frame_bits[k*BIT_CLKS+s] !== frame_bits[k*BIT_CLKS]) mon_ok = 1'b0;
        if (frame_bits[0] !== 1'b0 || frame_bits[9*BIT_CLKS] !== 1'b1) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) mon_b[i] = frame_bits[(i+1)*BIT_CLKS];
        rx_bytes.push_back(mon_b);
        rx_start.push_back(fstart);
        rx_ok.push_back(mon_ok);
        in_frame = 1'b0;
      end
    end
  end

  // Expected 40-sample line waveform for one byte at 4 clocks per bit.
  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [63:0] w;
    w = '0;
    for (int s = 0; s < 10 * BIT_CLKS; s++) begin
      int k;
      k = s / BIT_CLKS;
      if (k == 0)      w[s] = 1'b0;
      else if (k == 9) w[s] = 1'b1;
      else             w[s] = b[k-1];
    end
    return w;
  endfunction

  // ------------------------------------------------------------ bus tasks
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    rdata = '0;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    iomem_valid = 1'b1;
    while (!got && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
      if (iomem_ready === 1'b1) begin
        got = 1'b1;
        rdata = iomem_rdata;
      end
    end
    if (!got) check("bus_timeout", 64'(iomem_ready), 64'h1);
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int waited);
    logic [31:0] dummy;
    bus_xfer(addr, wdata, wstrb, dummy, waited);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
    int w;
    bus_xfer(addr, 32'h0, 4'h0, rdata, w);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (rx_bytes.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check("frame_count", 64'(rx_bytes.size()), 64'(n));
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_start.delete();
    rx_ok.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    int          t_push;
    int          r0;
    int          f0;
    int          wt[6];
    logic [7:0]  burst[6];

    burst[0] = 8'hA5; burst[1] = 8'h01; burst[2] = 8'h02;
    burst[3] = 8'h03; burst[4] = 8'h04; burst[5] = 8'h05;

    // ---------------------------------------------------------- reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_ser_tx", 64'(ser_tx), 64'h1);
    check("rst_ready", 64'(iomem_ready), 64'h0);
    check("rst_rdata", 64'(iomem_rdata), 64'h0);
    bus_read(A_STATUS, rd);
    check("rst_status", 64'(rd), 64'h2);
    @(posedge clk); #1;
    check("ready_one_cycle", 64'(iomem_ready), 64'h0);
    bus_read(A_DIV, rd);
    check("rst_div", 64'(rd), 64'h67);
    @(posedge clk); #1;
    check("ready_pulse_count", 64'(ready_cycles), 64'd2);

    // ---------------------------------------------------------- single byte
    bus_write(A_DIV, 32'h3, 4'b0011, w);
    bus_read(A_DIV, rd);
    check("div_rw3", 64'(rd), 64'h3);
    repeat (2) @(posedge clk); #1;
    clear_rx();
    bus_write(A_DATA, 32'h55, 4'b0001, w);
    t_push = cyc;
    bus_read(A_STATUS, rd);
    check("status_busy", 64'(rd), 64'h6);
    wait_frames(1, 200);
    if (rx_bytes.size() >= 1) begin
      check("byte55", 64'(rx_bytes[0]), 64'h55);
      check("frame55_ok", 64'(rx_ok[0]), 64'h1);
      check("first_fall_latency", 64'(rx_start[0] - t_push), 64'd2);
    end
    check("wave55", 64'(frame_bits), exp_wave(8'h55));
    check("idle_after_frame", 64'(ser_tx), 64'h1);
    repeat (3) @(posedge clk); #1;
    bus_read(A_STATUS, rd);
    check("status_idle", 64'(rd), 64'h2);

    // ---------------------------------------------------------- burst / stall
    repeat (2) @(posedge clk); #1;
    clear_rx();
    for (int i = 0; i < 6; i++) bus_write(A_DATA, {24'h0, burst[i]}, 4'b0001, wt[i]);
    check("burst_wait0", 64'(wt[0]), 64'd1);
    for (int i = 1; i < 5; i++) check($sformatf("burst_wait%0d", i), 64'(wt[i]), 64'd2);
    check("burst_wait5_stall", 64'(wt[5]), 64'd34);
    wait_frames(6, 400);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_bytes.size()) begin
        check($sformatf("burst_byte%0d", i), 64'(rx_bytes[i]), 64'(burst[i]));
        check($sformatf("burst_ok%0d", i), 64'(rx_ok[i]), 64'h1);
        if (i > 0) check($sformatf("burst_gap%0d", i), 64'(rx_start[i] - rx_start[i-1]), 64'd40);
      end
    end

    // ---------------------------------------------------------- DIV lanes, clamp
    bus_write(A_DIV, 32'hFFFF_AB00, 4'b0010, w);
    bus_read(A_DIV, rd);
    check("div_hi_lane", 64'(rd), 64'hAB03);
    bus_write(A_DIV, 32'h0000_0011, 4'b0001, w);
    bus_read(A_DIV, rd);
    check("div_lo_lane", 64'(rd), 64'hAB11);
    bus_write(A_DIV, 32'h0, 4'b0011, w);
    bus_read(A_DIV, rd);
    check("div_zero_readback", 64'(rd), 64'h0);
    bus_write(A_R3, 32'hFFFF_FFFF, 4'hF, w);
    bus_read(A_R3, rd);
    check("reg3_read", 64'(rd), 64'h0);
    bus_read(A_DATA, rd);
    check("data_read", 64'(rd), 64'h0);
    bus_read(A_DIV, rd);
    check("div_after_reg3_write", 64'(rd), 64'h0);
    clear_rx();
    bus_write(A_DATA, 32'h3C, 4'b0001, w);
    wait_frames(1, 200);
    if (rx_bytes.size() >= 1) begin
      check("byte3c_clamped", 64'(rx_bytes[0]), 64'h3C);
      check("frame3c_ok", 64'(rx_ok[0]), 64'h1);
    end
    check("wave3c", 64'(frame_bits), exp_wave(8'h3C));

    // ---------------------------------------------------------- unselected
    repeat (4) @(posedge clk); #1;
    clear_rx();
    r0 = ready_cycles;
    f0 = fall_cnt;
    iomem_addr  = 32'h0300_0000;
    iomem_wdata = 32'h77;
    iomem_wstrb = 4'b0001;
    iomem_valid = 1'b1;
    repeat (20) @(posedge clk); #1;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    check("unsel_no_ready", 64'(ready_cycles - r0), 64'd0);
    repeat (10) @(posedge clk); #1;
    check("unsel_no_tx", 64'(fall_cnt - f0), 64'd0);
    bus_read(A_STATUS, rd);
    check("unsel_status", 64'(rd), 64'h2);

    // ---------------------------------------------------------- reset mid-byte
    clear_rx();
    bus_write(A_DATA, 32'h11, 4'b0001, w);
    bus_write(A_DATA, 32'h22, 4'b0001, w);
    bus_write(A_DATA, 32'h33, 4'b0001, w);
    begin
      int i;
      i = 0;
      while (!(in_frame && fidx >= 17) && i < 200) begin
        @(posedge clk); #1;
        i++;
      end
    end
    check("reached_data_bit3", 64'(in_frame && fidx == 17), 64'h1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ser_tx", 64'(ser_tx), 64'h1);
    resetn = 1'b1;
    f0 = fall_cnt;
    bus_read(A_STATUS, rd);
    check("rst_mid_status", 64'(rd), 64'h2);
    bus_read(A_DIV, rd);
    check("rst_mid_div", 64'(rd), 64'h67);
    repeat (100) @(posedge clk); #1;
    check("rst_mid_no_output", 64'(fall_cnt - f0), 64'd0);
    check("rst_mid_no_frames", 64'(rx_bytes.size()), 64'd0);
    check("rst_mid_line_idle", 64'(ser_tx), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
